spi_cmd_sequencer: RTL and testbench

Command-driven controller that sequences the SPI master from a show-ahead command FIFO. It fetches 16-bit command words written by the MCU and asserts/deasserts CS under command control. It issues byte transfers through the SPI master's go/state handshake, pushes captured receive bytes into a response FIFO, and inserts programmable delays. It sits between FIFO_IN / a response FIFO and the SPI master.

---
 rtl/spi_cmd_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_spi_cmd_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: fetches 16-bit command words from a show-ahead FIFO and
// drives chip select, SPI byte transfers, response pushes and timed delays.
// Optional SPI watchdog: define SEQ_TIMEOUT_EN to build it in. Without it
// err_timeout is tied low and the sequencer waits on spi_busy indefinitely.
module spi_cmd_sequencer #(
    parameter logic        CS_ACTIVE = 1'b0,
    parameter int unsigned DELAY_W   = 12,
    parameter int unsigned TIMEOUT_W = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        cmd_nempty,
    input  logic [15:0] cmd_data,
    output logic        cmd_pop,
    input  logic        rsp_full,
    output logic        rsp_push,
    output logic [7:0]  rsp_data,
    output logic        spi_go,
    output logic [7:0]  spi_din,
    input  logic        spi_busy,
    input  logic [7:0]  spi_dout,
    output logic        cs_out,
    output logic        busy,
    output logic        err_illegal,
    output logic        err_timeout,
    input  logic        clr_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_WAIT_START,
        S_WAIT_DONE,
        S_DELAY
    } state_e;

    typedef enum logic [3:0] {
        OP_NOP        = 4'h0,
        OP_CS_ASSERT  = 4'h1,
        OP_CS_RELEASE = 4'h2,
        OP_WRITE      = 4'h3,
        OP_XFER       = 4'h4,
        OP_DELAY      = 4'h5
    } opcode_e;

    // Operand field limits: DELAY count must fit the 12-bit operand.
    if (DELAY_W < 2 || DELAY_W > 12 || TIMEOUT_W < 2) begin : g_bad_params
        $error("spi_cmd_sequencer: DELAY_W must be 2..12 and TIMEOUT_W >= 2");
    end

    state_e               state_q, state_d;
    logic [15:0]          cmd_q, cmd_d;
    logic                 cs_q, cs_d;
    logic [7:0]           din_q, din_d;
    logic                 go_q, go_d;
    logic                 push_q, push_d;
    logic [7:0]           rdata_q, rdata_d;
    logic [DELAY_W-1:0]   cnt_q, cnt_d;
    logic                 ill_q, ill_d;

    logic [3:0]           opcode;
    logic [DELAY_W-1:0]   delay_operand;

    assign opcode        = cmd_q[15:12];
    assign delay_operand = cmd_q[DELAY_W-1:0];

`ifdef SEQ_TIMEOUT_EN
    // Watchdog fires on the (2^TIMEOUT_W - 1)th cycle spent in one wait state.
    localparam logic [TIMEOUT_W-1:0] WD_LIMIT = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic                 to_q, to_d;
`endif

    // Next-state, command decode and registered-output updates.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        cs_d    = cs_q;
        din_d   = din_q;
        go_d    = 1'b0;
        push_d  = 1'b0;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        ill_d   = ill_q & ~clr_err;
        cmd_pop = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        wd_d    = '0;
        to_d    = to_q & ~clr_err;
`endif

        unique case (state_q)
            S_IDLE: begin
                // Pop is combinational so the FIFO word and the pop share a cycle;
                // gating with reset keeps it low while reset is held.
                if (reset && enable && cmd_nempty) begin
                    cmd_pop = 1'b1;
                    cmd_d   = cmd_data;
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                case (opcode)
                    OP_NOP: begin
                        state_d = S_IDLE;
                    end
                    OP_CS_ASSERT: begin
                        cs_d    = CS_ACTIVE;
                        state_d = S_IDLE;
                    end
                    OP_CS_RELEASE: begin
                        cs_d    = ~CS_ACTIVE;
                        state_d = S_IDLE;
                    end
                    OP_WRITE, OP_XFER: begin
                        if (!(opcode == OP_XFER && rsp_full)) begin
                            din_d   = cmd_q[7:0];
                            go_d    = 1'b1;
                            state_d = S_WAIT_START;
                        end
                    end
                    OP_DELAY: begin
                        // EXEC itself is the first delay cycle.
                        cnt_d = delay_operand;
                        if (delay_operand <= DELAY_W'(1)) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DELAY;
                        end
                    end
                    default: begin
                        ill_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                endcase
            end

            S_WAIT_START: begin
                if (spi_busy) begin
                    state_d = S_WAIT_DONE;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (wd_q == WD_LIMIT) begin
                    to_d    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q + TIMEOUT_W'(1);
                end
`endif
            end

            S_WAIT_DONE: begin
                if (!spi_busy) begin
                    if (opcode == OP_XFER) begin
                        rdata_d = spi_dout;
                        push_d  = 1'b1;
                    end
                    state_d = S_IDLE;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (wd_q == WD_LIMIT) begin
                    to_d    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q + TIMEOUT_W'(1);
                end
`endif
            end

            S_DELAY: begin
                cnt_d = cnt_q - DELAY_W'(1);
                if (cnt_q <= DELAY_W'(2)) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer and releases CS.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            cs_q    <= ~CS_ACTIVE;
            din_q   <= '0;
            go_q    <= 1'b0;
            push_q  <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            cs_q    <= cs_d;
            din_q   <= din_d;
            go_q    <= go_d;
            push_q  <= push_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    // Watchdog counter and sticky timeout flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            to_q <= to_d;
        end
    end

    assign err_timeout = to_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign busy        = (state_q != S_IDLE);
    assign spi_go      = go_q;
    assign spi_din     = din_q;
    assign rsp_push    = push_q;
    assign rsp_data    = rdata_q;
    assign cs_out      = cs_q;
    assign err_illegal = ill_q;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed bench for spi_cmd_sequencer with a looping SPI responder,
// a command FIFO model and scoreboard queues for spi_din / rsp_data.
module tb_spi_cmd_sequencer;

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned TB_TW = 4;
`else
    localparam int unsigned TB_TW = 16;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        cmd_nempty;
    logic [15:0] cmd_data;
    logic        cmd_pop;
    logic        rsp_full;
    logic        rsp_push;
    logic [7:0]  rsp_data;
    logic        spi_go;
    logic [7:0]  spi_din;
    logic        spi_busy;
    logic [7:0]  spi_dout;
    logic        cs_out;
    logic        busy;
    logic        err_illegal;
    logic        err_timeout;
    logic        clr_err;

    logic [15:0] cmd_mem [0:63];
    logic [5:0]  wr_ptr = '0;
    logic [5:0]  rd_ptr = '0;
    assign cmd_nempty = (wr_ptr != rd_ptr);
    assign cmd_data   = cmd_mem[rd_ptr];

    logic [7:0] exp_din[$];
    logic [7:0] exp_rsp[$];

    int errors = 0;
    int checks = 0;
    int pops, gos, pushes, busy_cyc, act_cyc;
    logic cs_low_seen;
    logic spi_hang = 1'b0;
    logic spi_mute = 1'b0;

    spi_cmd_sequencer #(
        .CS_ACTIVE (1'b0),
        .DELAY_W   (12),
        .TIMEOUT_W (TB_TW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .cmd_nempty  (cmd_nempty),
        .cmd_data    (cmd_data),
        .cmd_pop     (cmd_pop),
        .rsp_full    (rsp_full),
        .rsp_push    (rsp_push),
        .rsp_data    (rsp_data),
        .spi_go      (spi_go),
        .spi_din     (spi_din),
        .spi_busy    (spi_busy),
        .spi_dout    (spi_dout),
        .cs_out      (cs_out),
        .busy        (busy),
        .err_illegal (err_illegal),
        .err_timeout (err_timeout),
        .clr_err     (clr_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push_cmd(input logic [15:0] w);
        cmd_mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 6'd1;
    endtask

    task automatic clr_cnt();
        pops = 0; gos = 0; pushes = 0; busy_cyc = 0; act_cyc = 0; cs_low_seen = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < budget) begin
            @(negedge clock);
            n++;
            if (wr_ptr == rd_ptr && !busy && !spi_busy && !cmd_pop) quiet++;
            else quiet = 0;
        end
        check({tag, "_idle"}, 32'(quiet >= 3), 32'd1);
        @(posedge clock);
        #1;
    endtask

    // Monitor: samples outputs mid-cycle, scores spi_go / rsp_push, retires FIFO pops.
    initial begin
        logic popped;
        clr_cnt();
        forever begin
            @(negedge clock);
            popped = 1'b0;
            if (reset) begin
                if (cmd_pop) begin
                    pops++;
                    popped = 1'b1;
                end
                if (cmd_pop || busy) act_cyc++;
                if (busy) busy_cyc++;
                if (cs_out == 1'b0) cs_low_seen = 1'b1;
                if (spi_go) begin
                    gos++;
                    if (exp_din.size() == 0) check("go_unexpected", 32'd1, 32'd0);
                    else check("spi_din", 32'(spi_din), 32'(exp_din.pop_front()));
                end
                if (rsp_push) begin
                    pushes++;
                    if (exp_rsp.size() == 0) check("push_unexpected", 32'd1, 32'd0);
                    else check("rsp_data", 32'(rsp_data), 32'(exp_rsp.pop_front()));
                end
            end
            if (popped) begin
                @(posedge clock);
                #1;
                rd_ptr = rd_ptr + 6'd1;
            end
        end
    end

    // SPI master model: loops MOSI back to MISO after a short busy period.
    initial begin
        logic [7:0] mosi;
        spi_busy = 1'b0;
        spi_dout = '0;
        forever begin
            @(negedge clock);
            if (reset && spi_go && !spi_mute) begin
                mosi = spi_din;
                @(negedge clock);
                spi_busy = 1'b1;
                repeat (3) @(negedge clock);
                for (int k = 0; k < 2000 && spi_hang; k++) @(negedge clock);
                spi_dout = mosi;
                spi_busy = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed hang expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        reset = 1'b0; enable = 1'b1; rsp_full = 1'b0; clr_err = 1'b0;

        // Reset values, with commands already waiting in the FIFO.
        push_cmd(16'h1000); push_cmd(16'h40A5); push_cmd(16'h2000);
        exp_din.push_back(8'hA5); exp_rsp.push_back(8'hA5);
        step(3);
        check("rst_cs_out",   32'(cs_out),      32'd1);
        check("rst_busy",     32'(busy),        32'd0);
        check("rst_cmd_pop",  32'(cmd_pop),     32'd0);
        check("rst_spi_go",   32'(spi_go),      32'd0);
        check("rst_rsp_push", 32'(rsp_push),    32'd0);
        check("rst_spi_din",  32'(spi_din),     32'd0);
        check("rst_rsp_data", 32'(rsp_data),    32'd0);
        check("rst_err_ill",  32'(err_illegal), 32'd0);
        check("rst_err_to",   32'(err_timeout), 32'd0);

        // CS assert, XFER 0xA5, CS release.
        clr_cnt();
        reset = 1'b1;
        wait_idle("t1", 200);
        check("t1_pops",   32'(pops),        32'd3);
        check("t1_gos",    32'(gos),         32'd1);
        check("t1_pushes", 32'(pushes),      32'd1);
        check("t1_cs_low", 32'(cs_low_seen), 32'd1);
        check("t1_cs_end", 32'(cs_out),      32'd1);

        // WRITE 0x55: transmit only.
        clr_cnt();
        exp_din.push_back(8'h55);
        push_cmd(16'h3055);
        wait_idle("t2", 100);
        check("t2_gos",    32'(gos),    32'd1);
        check("t2_pushes", 32'(pushes), 32'd0);

        // XFER stalls while the response FIFO is full.
        clr_cnt();
        rsp_full = 1'b1;
        exp_din.push_back(8'h11); exp_rsp.push_back(8'h11);
        push_cmd(16'h4011);
        step(20);
        check("t3_stall_busy", 32'(busy), 32'd1);
        check("t3_stall_gos",  32'(gos),  32'd0);
        check("t3_stall_pops", 32'(pops), 32'd1);
        rsp_full = 1'b0;
        wait_idle("t3", 100);
        check("t3_gos",    32'(gos),    32'd1);
        check("t3_pushes", 32'(pushes), 32'd1);

        // DELAY 16 and DELAY 0.
        clr_cnt();
        push_cmd(16'h5010);
        wait_idle("t4a", 100);
        check("t4a_active", 32'(act_cyc),  32'd17);
        check("t4a_busy",   32'(busy_cyc), 32'd16);
        clr_cnt();
        push_cmd(16'h5000);
        wait_idle("t4b", 100);
        check("t4b_active", 32'(act_cyc),  32'd2);
        check("t4b_busy",   32'(busy_cyc), 32'd1);

        // Illegal opcode, clear, then a normal XFER.
        clr_cnt();
        push_cmd(16'h9123);
        wait_idle("t5", 100);
        check("t5_err_ill", 32'(err_illegal), 32'd1);
        check("t5_gos",     32'(gos),         32'd0);
        check("t5_cs",      32'(cs_out),      32'd1);
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        step(1);
        check("t5_cleared", 32'(err_illegal), 32'd0);
        clr_cnt();
        exp_din.push_back(8'hC3); exp_rsp.push_back(8'hC3);
        push_cmd(16'h40C3);
        wait_idle("t5b", 100);
        check("t5b_gos",    32'(gos),    32'd1);
        check("t5b_pushes", 32'(pushes), 32'd1);

        // clr_err during the cycle an illegal opcode executes: error wins.
        push_cmd(16'hF000);
        step(1);
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        check("t6_err_wins", 32'(err_illegal), 32'd1);
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        step(1);
        check("t6_cleared", 32'(err_illegal), 32'd0);

        // enable low: no fetch; enable dropped mid-command: finish, no next fetch.
        clr_cnt();
        enable = 1'b0;
        push_cmd(16'h0000);
        step(6);
        check("t7_no_pop",  32'(pops), 32'd0);
        check("t7_no_busy", 32'(busy), 32'd0);
        enable = 1'b1;
        wait_idle("t7", 50);
        check("t7_pop", 32'(pops), 32'd1);
        clr_cnt();
        push_cmd(16'h5008);
        push_cmd(16'h0000);
        step(1);
        enable = 1'b0;
        step(20);
        check("t8_pops",    32'(pops),                 32'd1);
        check("t8_idle",    32'(busy),                 32'd0);
        check("t8_pending", 32'(wr_ptr != rd_ptr),     32'd1);
        enable = 1'b1;
        wait_idle("t8", 50);
        check("t8_pops_end", 32'(pops), 32'd2);

        // Reset asserted while an XFER sits in WAIT_DONE.
        clr_cnt();
        spi_hang = 1'b1;
        exp_din.push_back(8'h77);
        push_cmd(16'h1000);
        push_cmd(16'h4077);
        for (int n = 0; n < 100 && !spi_busy; n++) @(negedge clock);
        repeat (2) @(negedge clock);
        check("t9_pre_busy", 32'(busy),   32'd1);
        check("t9_pre_cs",   32'(cs_out), 32'd0);
        reset = 1'b0;
        #1;
        check("t9_cs",       32'(cs_out),   32'd1);
        check("t9_busy",     32'(busy),     32'd0);
        check("t9_spi_go",   32'(spi_go),   32'd0);
        check("t9_rsp_push", 32'(rsp_push), 32'd0);
        check("t9_spi_din",  32'(spi_din),  32'd0);
        check("t9_rsp_data", 32'(rsp_data), 32'd0);
        check("t9_cmd_pop",  32'(cmd_pop),  32'd0);
        spi_hang = 1'b0;
        step(4);
        reset = 1'b1;
        wait_idle("t9", 50);
        check("t9_pushes", 32'(pushes), 32'd0);
        check("t9_cs_end", 32'(cs_out), 32'd1);

`ifdef SEQ_TIMEOUT_EN
        // Stuck SPI master: watchdog after 15 cycles in WAIT_START, CS kept.
        clr_cnt();
        spi_mute = 1'b1;
        exp_din.push_back(8'h33);
        push_cmd(16'h1000);
        push_cmd(16'h4033);
        wait_idle("t10", 200);
        check("t10_busy_cyc", 32'(busy_cyc),    32'd17);
        check("t10_err_to",   32'(err_timeout), 32'd1);
        check("t10_pushes",   32'(pushes),      32'd0);
        check("t10_cs_kept",  32'(cs_out),      32'd0);
        spi_mute = 1'b0;
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        push_cmd(16'h2000);
        wait_idle("t10b", 50);
        check("t10_err_clr", 32'(err_timeout), 32'd0);
        check("t10_cs_end",  32'(cs_out),      32'd1);
`else
        check("no_wd_err_to", 32'(err_timeout), 32'd0);
`endif

        check("sb_din_empty", 32'(exp_din.size()), 32'd0);
        check("sb_rsp_empty", 32'(exp_rsp.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
